regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: the ALU result path and the load/store unit (LSU) load-return path.
- Each source uses a valid/ready handshake. A round-robin arbiter grants one source per cycle.
- The granted write is registered and driven onto the register file's write_enable, write_addr and write_data inputs one cycle later.
- Writes to x0 are accepted and dropped, so the port never carries an x0 write.

Parameters:
- REG_SIZE, 32, data width of one architectural register.
- REG_WIDTH, 5, register address width (32 architectural registers).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request granted this cycle
- alu_addr  in  REG_WIDTH  ALU destination register
- alu_data  in  REG_SIZE  ALU result
- lsu_valid  in  1  LSU writeback request
- lsu_ready  out  1  LSU request granted this cycle
- lsu_addr  in  REG_WIDTH  LSU destination register
- lsu_data  in  REG_SIZE  load data
- write_enable  out  1  register-file write strobe
- write_addr  out  REG_WIDTH  register-file write address
- write_data  out  REG_SIZE  register-file write data
- grant_lsu  out  1  source of the current write_enable pulse (0=ALU, 1=LSU)

Behaviour:
- Reset (rst_n low, asynchronous):
  - write_enable=0, write_addr=0, write_data=0, grant_lsu=0.
  - Priority pointer = ALU.
  - Any in-flight registered write is discarded immediately.
- Handshake:
  - A transfer occurs on a rising edge where valid && ready.
  - Requesters hold valid, addr and data stable until ready is seen.
  - valid must not depend on ready.
  - ready is combinational from both valids and the pointer. It is never asserted to a source whose valid is low.
- Arbitration:
  - Only one source valid: that source is granted, regardless of the pointer.
  - Both valid: the source named by the pointer is granted.
  - At most one ready is high per cycle.
  - The register file never back-pressures, so one grant occurs every cycle any valid is high.
- Pointer update:
  - Updates only on a grant: after an ALU grant the pointer becomes LSU; after an LSU grant it becomes ALU.
  - No grant: the pointer holds.
  - Result: worst-case wait for a continuously valid source is 1 cycle.
- Output stage (latency 1 cycle from handshake edge):
  - On a grant, write_addr, write_data and grant_lsu capture the winner's addr, data and identity.
  - write_enable=1 for exactly one cycle if the winner's addr != 0. If addr == 0 the transfer completes (ready high) but write_enable=0.
  - No grant: write_enable=0; write_addr, write_data and grant_lsu hold their last values.
- Back-to-back grants produce consecutive write_enable pulses; throughput is 1 write/cycle.
- Same destination requested by both sources simultaneously: the writes are serialized in grant order. The later write lands last and wins.
- Loser behaviour: ready stays low; the loser keeps valid high and is granted the next cycle.
- Reset deasserting mid-stream: the first grant after reset favours ALU when both are valid.

Test Plan:
- Reset then idle: rst_n=0 with both valids high -> both ready=0, write_enable=0, write_addr=0, write_data=0. After release, write_enable stays 0 until a valid is seen.
- ALU only: alu_valid=1, addr=5, data=0xDEADBEEF for 1 cycle -> alu_ready=1 that cycle; next cycle write_enable=1, write_addr=5, write_data=0xDEADBEEF, grant_lsu=0; following cycle write_enable=0.
- Contention: both valid continuously for 4 cycles (ALU addr 1/data 0x11, LSU addr 2/data 0x22) -> grants alternate ALU, LSU, ALU, LSU. write_addr sequence is 1,2,1,2 with write_enable high 4 consecutive cycles; grant_lsu toggles 0,1,0,1.
- x0 drop: lsu_valid=1, lsu_addr=0, data=0xFFFFFFFF -> lsu_ready=1; next cycle write_enable=0. The next LSU/ALU contention favours ALU, because the pointer advanced past LSU.
- Same-address collision: both valid with addr 7 (ALU data 0xA, LSU data 0xB), pointer=LSU -> LSU write first, ALU write next; register 7 ends with 0xA.
- Reset mid-operation: assert rst_n low asynchronously while write_enable=1 -> write_enable drops to 0 before the next clock edge. After release with both valid, ALU is granted first.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// and LSU writeback sources, with a one-cycle registered write stage.
module regfile_wb_arbiter #(
    parameter int REG_SIZE  = 32,
    parameter int REG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [REG_WIDTH-1:0] alu_addr,
    input  logic [REG_SIZE-1:0]  alu_data,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [REG_WIDTH-1:0] lsu_addr,
    input  logic [REG_SIZE-1:0]  lsu_data,
    output logic                 write_enable,
    output logic [REG_WIDTH-1:0] write_addr,
    output logic [REG_SIZE-1:0]  write_data,
    output logic                 grant_lsu
);

    typedef enum logic {
        PTR_ALU = 1'b0,
        PTR_LSU = 1'b1
    } ptr_e;

    ptr_e                 ptr_q, ptr_d;
    logic                 we_q, we_d;
    logic [REG_WIDTH-1:0] waddr_q, waddr_d;
    logic [REG_SIZE-1:0]  wdata_q, wdata_d;
    logic                 glsu_q, glsu_d;

    logic                 alu_win;
    logic                 lsu_win;

    // Grants are suppressed while reset is held so no handshake completes
    // into a flop that is being cleared.
    always_comb begin
        alu_win = 1'b0;
        lsu_win = 1'b0;
        if (rst_n) begin
            if (alu_valid && (!lsu_valid || ptr_q == PTR_ALU)) begin
                alu_win = 1'b1;
            end else if (lsu_valid) begin
                lsu_win = 1'b1;
            end
        end
    end

    assign alu_ready = alu_win;
    assign lsu_ready = lsu_win;

    always_comb begin
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        glsu_d  = glsu_q;
        if (alu_win) begin
            ptr_d   = PTR_LSU;
            we_d    = (alu_addr != '0);
            waddr_d = alu_addr;
            wdata_d = alu_data;
            glsu_d  = 1'b0;
        end else if (lsu_win) begin
            ptr_d   = PTR_ALU;
            we_d    = (lsu_addr != '0);
            waddr_d = lsu_addr;
            wdata_d = lsu_data;
            glsu_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= PTR_ALU;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            glsu_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            glsu_q  <= glsu_d;
        end
    end

    assign write_enable = we_q;
    assign write_addr   = waddr_q;
    assign write_data   = wdata_q;
    assign grant_lsu    = glsu_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a
// turn-taking reference model plus a shadow register file.
module tb_regfile_wb_arbiter;

    localparam int RS = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, lsu_valid;
    logic          alu_ready, lsu_ready;
    logic [RW-1:0] alu_addr, lsu_addr;
    logic [RS-1:0] alu_data, lsu_data;
    logic          write_enable;
    logic [RW-1:0] write_addr;
    logic [RS-1:0] write_data;
    logic          grant_lsu;

    regfile_wb_arbiter #(.REG_SIZE(RS), .REG_WIDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_addr(alu_addr), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .lsu_addr(lsu_addr), .lsu_data(lsu_data),
        .write_enable(write_enable), .write_addr(write_addr),
        .write_data(write_data), .grant_lsu(grant_lsu)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: whose turn it is under contention, and the expected
    // contents of the registered write port.
    bit            turn_lsu;
    bit            m_we;
    logic [RW-1:0] m_addr;
    logic [RS-1:0] m_data;
    bit            m_glsu;
    logic [RS-1:0] rf_dut [32];
    int            won_log [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        turn_lsu = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        m_glsu   = 1'b0;
    endtask

    // One clock: check ready before the edge, then the write port after it.
    // won: 0 none, 1 ALU, 2 LSU.
    task automatic step(input string tag, output int won);
        logic [RW-1:0] a;
        logic [RS-1:0] d;
        @(negedge clk);
        if (alu_valid && lsu_valid) won = turn_lsu ? 2 : 1;
        else if (alu_valid)         won = 1;
        else if (lsu_valid)         won = 2;
        else                        won = 0;
        check({tag, ".alu_ready"}, alu_ready, (won == 1));
        check({tag, ".lsu_ready"}, lsu_ready, (won == 2));
        a = (won == 2) ? lsu_addr : alu_addr;
        d = (won == 2) ? lsu_data : alu_data;
        @(posedge clk);
        #1;
        if (won != 0) begin
            m_we     = (a != 0);
            m_addr   = a;
            m_data   = d;
            m_glsu   = (won == 2);
            turn_lsu = (won == 1);
        end else begin
            m_we = 1'b0;
        end
        check({tag, ".we"}, write_enable, m_we);
        check({tag, ".addr"}, write_addr, m_addr);
        check({tag, ".data"}, write_data, m_data);
        check({tag, ".glsu"}, grant_lsu, m_glsu);
        check({tag, ".no_x0"}, (write_enable && write_addr == 0), 1'b0);
        if (write_enable) rf_dut[write_addr] = write_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int won;
        logic [RW-1:0] exp_seq [4];
        for (int i = 0; i < 32; i++) rf_dut[i] = '0;
        model_reset();

        // Reset with both sources requesting.
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h3333;
        lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_data = 32'h4444;
        #12;
        check("rst.alu_ready", alu_ready, 1'b0);
        check("rst.lsu_ready", lsu_ready, 1'b0);
        check("rst.we", write_enable, 1'b0);
        check("rst.addr", write_addr, '0);
        check("rst.data", write_data, '0);
        check("rst.glsu", grant_lsu, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        alu_valid = 1'b0; lsu_valid = 1'b0;
        step("idle0", won);
        step("idle1", won);

        // ALU only.
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        step("alu1", won);
        check("alu1.won", won, 1);
        alu_valid = 1'b0;
        step("alu1_after", won);

        // x0 load: accepted, dropped, pointer moves back to ALU.
        lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'hFFFFFFFF;
        step("x0", won);
        check("x0.won", won, 2);
        lsu_valid = 1'b0;
        step("x0_after", won);
        check("x0_after.we", write_enable, 1'b0);

        // Contention: must alternate starting with ALU.
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_addr = 5'd2; lsu_data = 32'h22;
        exp_seq[0] = 5'd1; exp_seq[1] = 5'd2; exp_seq[2] = 5'd1; exp_seq[3] = 5'd2;
        for (int i = 0; i < 4; i++) begin
            step($sformatf("cont%0d", i), won);
            check($sformatf("cont%0d.seq_addr", i), write_addr, exp_seq[i]);
            check($sformatf("cont%0d.seq_we", i), write_enable, 1'b1);
            check($sformatf("cont%0d.seq_glsu", i), grant_lsu, (i % 2));
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;

        // Collision on x7 with the pointer at LSU: LSU lands first, ALU wins.
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
        step("pre_coll", won);
        alu_addr = 5'd7; alu_data = 32'hA;
        lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'hB;
        step("coll0", won);
        check("coll0.won", won, 2);
        lsu_valid = 1'b0;
        step("coll1", won);
        check("coll1.won", won, 1);
        alu_valid = 1'b0;
        step("coll_idle", won);
        check("coll.rf7", rf_dut[7], 32'hA);

        // Randomized traffic; each source holds its request until granted.
        for (int n = 0; n < 400; n++) begin
            if (!alu_valid && ($urandom % 3 != 0)) begin
                alu_valid = 1'b1;
                alu_addr  = RW'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!lsu_valid && ($urandom % 3 != 0)) begin
                lsu_valid = 1'b1;
                lsu_addr  = RW'($urandom_range(0, 31));
                lsu_data  = $urandom;
            end
            step("rand", won);
            won_log.push_back(won);
            if (won == 1) alu_valid = 1'b0;
            if (won == 2) lsu_valid = 1'b0;
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;

        // Asynchronous reset while a write is on the port.
        alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'hC0FFEE;
        step("pre_rst", won);
        check("pre_rst.we_high", write_enable, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.we", write_enable, 1'b0);
        check("arst.addr", write_addr, '0);
        check("arst.data", write_data, '0);
        check("arst.glsu", grant_lsu, 1'b0);
        model_reset();
        alu_valid = 1'b1; alu_addr = 5'd13; alu_data = 32'h1313;
        lsu_valid = 1'b1; lsu_addr = 5'd14; lsu_data = 32'h1414;
        #1;
        check("arst.alu_ready", alu_ready, 1'b0);
        check("arst.lsu_ready", lsu_ready, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        step("post_rst", won);
        check("post_rst.won", won, 1);
        alu_valid = 1'b0;
        step("post_rst2", won);
        check("post_rst2.won", won, 2);
        lsu_valid = 1'b0;
        step("post_rst_idle", won);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
